// File: rtl/reorder_buffer_if.sv
// Issue, completion, broadcast, operand-query and retire signals of the reorder buffer.
// The master side is the core pipeline; the slave side is the ROB itself.
interface reorder_buffer_if;
    logic        rdy_in;
    logic        flush;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic [3:0]  alloc_tag;
    logic        rob_full;
    logic        alu_valid;
    logic [3:0]  alu_tag;
    logic [31:0] alu_val;
    logic        lsb_valid;
    logic [3:0]  lsb_tag;
    logic [31:0] lsb_val;
    logic        cdb_active;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_val;
    logic [3:0]  query_tag1;
    logic [3:0]  query_tag2;
    logic        query_ready1;
    logic        query_ready2;
    logic [31:0] query_val1;
    logic [31:0] query_val2;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [3:0]  commit_tag;
    logic [31:0] commit_val;

    modport master (
        output rdy_in, flush, alloc_valid, alloc_rd,
        output alu_valid, alu_tag, alu_val, lsb_valid, lsb_tag, lsb_val,
        output query_tag1, query_tag2,
        input  alloc_tag, rob_full, cdb_active, cdb_tag, cdb_val,
        input  query_ready1, query_ready2, query_val1, query_val2,
        input  commit_valid, commit_rd, commit_tag, commit_val
    );

    modport slave (
        input  rdy_in, flush, alloc_valid, alloc_rd,
        input  alu_valid, alu_tag, alu_val, lsb_valid, lsb_tag, lsb_val,
        input  query_tag1, query_tag2,
        output alloc_tag, rob_full, cdb_active, cdb_tag, cdb_val,
        output query_ready1, query_ready2, query_val1, query_val2,
        output commit_valid, commit_rd, commit_tag, commit_val
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags, collects ALU/LSB results, broadcasts them on the CDB
// oldest-first and retires entries in program order. Entry i carries tag i+1; tag 0 means none.
module reorder_buffer #(
    parameter int DEPTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    reorder_buffer_if.slave  bus
);

    // Storage is sized to the full 4-bit tag space so tag-derived indices select exactly;
    // slots at or above DEPTH are never written.
    localparam int         SLOTS   = 16;
    localparam logic [3:0] LAST    = 4'(DEPTH - 1);
    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    logic [SLOTS-1:0] busy_q, busy_d;
    logic [SLOTS-1:0] done_q, done_d;
    logic [SLOTS-1:0] bcast_q, bcast_d;
    logic [4:0]       rd_q  [SLOTS];
    logic [4:0]       rd_d  [SLOTS];
    logic [31:0]      val_q [SLOTS];
    logic [31:0]      val_d [SLOTS];
    logic [3:0]       head_q, head_d;
    logic [3:0]       tail_q, tail_d;
    logic [3:0]       count_q, count_d;

    logic             cdb_active_q, cdb_active_d;
    logic [3:0]       cdb_tag_q, cdb_tag_d;
    logic [31:0]      cdb_val_q, cdb_val_d;
    logic             commit_valid_q, commit_valid_d;
    logic [4:0]       commit_rd_q, commit_rd_d;
    logic [3:0]       commit_tag_q, commit_tag_d;
    logic [31:0]      commit_val_q, commit_val_d;

    logic             full;
    logic             alloc_fire;
    logic             commit_fire;
    logic [3:0]       alu_idx, lsb_idx;
    logic             alu_hit, lsb_hit;
    logic             cdb_found;
    logic [3:0]       cdb_idx;
    logic [3:0]       scan_ptr;
    logic [3:0]       q1_idx, q2_idx;

    function automatic logic [3:0] ptr_inc(input logic [3:0] p);
        return (p == LAST) ? 4'd0 : p + 4'd1;
    endfunction

    function automatic logic tag_ok(input logic [3:0] t);
        return (t != 4'd0) && (t <= DEPTH_L);
    endfunction

    assign full        = (count_q == DEPTH_L);
    assign alloc_fire  = bus.rdy_in && bus.alloc_valid && !full && !bus.flush;
    assign commit_fire = busy_q[head_q] && done_q[head_q] && bcast_q[head_q];

    assign alu_idx = bus.alu_tag - 4'd1;
    assign lsb_idx = bus.lsb_tag - 4'd1;
    assign alu_hit = bus.alu_valid && tag_ok(bus.alu_tag) && busy_q[alu_idx] && !done_q[alu_idx];
    // On a same-tag collision the ALU result is the one kept.
    assign lsb_hit = bus.lsb_valid && tag_ok(bus.lsb_tag) && busy_q[lsb_idx] && !done_q[lsb_idx]
                     && !(alu_hit && (bus.alu_tag == bus.lsb_tag));

    // Oldest done-but-unbroadcast entry, scanning forward from head.
    always_comb begin
        cdb_found = 1'b0;
        cdb_idx   = 4'd0;
        scan_ptr  = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (!cdb_found && busy_q[scan_ptr] && done_q[scan_ptr] && !bcast_q[scan_ptr]) begin
                cdb_found = 1'b1;
                cdb_idx   = scan_ptr;
            end
            scan_ptr = ptr_inc(scan_ptr);
        end
    end

    always_comb begin
        busy_d         = busy_q;
        done_d         = done_q;
        bcast_d        = bcast_q;
        rd_d           = rd_q;
        val_d          = val_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        cdb_active_d   = 1'b0;
        cdb_tag_d      = 4'd0;
        cdb_val_d      = 32'd0;
        commit_valid_d = 1'b0;
        commit_rd_d    = 5'd0;
        commit_tag_d   = 4'd0;
        commit_val_d   = 32'd0;
        if (bus.flush) begin
            busy_d  = '0;
            done_d  = '0;
            bcast_d = '0;
            head_d  = 4'd0;
            tail_d  = 4'd0;
            count_d = 4'd0;
        end else begin
            if (alloc_fire) begin
                busy_d[tail_q]  = 1'b1;
                done_d[tail_q]  = 1'b0;
                bcast_d[tail_q] = 1'b0;
                rd_d[tail_q]    = bus.alloc_rd;
                tail_d          = ptr_inc(tail_q);
            end
            if (alu_hit) begin
                done_d[alu_idx] = 1'b1;
                val_d[alu_idx]  = bus.alu_val;
            end
            if (lsb_hit) begin
                done_d[lsb_idx] = 1'b1;
                val_d[lsb_idx]  = bus.lsb_val;
            end
            if (cdb_found) begin
                bcast_d[cdb_idx] = 1'b1;
                cdb_active_d     = 1'b1;
                cdb_tag_d        = cdb_idx + 4'd1;
                cdb_val_d        = val_q[cdb_idx];
            end
            if (commit_fire) begin
                busy_d[head_q]  = 1'b0;
                done_d[head_q]  = 1'b0;
                bcast_d[head_q] = 1'b0;
                commit_valid_d  = 1'b1;
                commit_rd_d     = rd_q[head_q];
                commit_tag_d    = head_q + 4'd1;
                commit_val_d    = val_q[head_q];
                head_d          = ptr_inc(head_q);
            end
            count_d = count_q + {3'd0, alloc_fire} - {3'd0, commit_fire};
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q         <= '0;
            done_q         <= '0;
            bcast_q        <= '0;
            head_q         <= 4'd0;
            tail_q         <= 4'd0;
            count_q        <= 4'd0;
            cdb_active_q   <= 1'b0;
            cdb_tag_q      <= 4'd0;
            cdb_val_q      <= 32'd0;
            commit_valid_q <= 1'b0;
            commit_rd_q    <= 5'd0;
            commit_tag_q   <= 4'd0;
            commit_val_q   <= 32'd0;
        end else if (bus.rdy_in) begin
            busy_q         <= busy_d;
            done_q         <= done_d;
            bcast_q        <= bcast_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            cdb_active_q   <= cdb_active_d;
            cdb_tag_q      <= cdb_tag_d;
            cdb_val_q      <= cdb_val_d;
            commit_valid_q <= commit_valid_d;
            commit_rd_q    <= commit_rd_d;
            commit_tag_q   <= commit_tag_d;
            commit_val_q   <= commit_val_d;
        end
    end

    // Entry payload is only meaningful while busy, so it carries no reset.
    always_ff @(posedge clk_in) begin
        if (bus.rdy_in) begin
            rd_q  <= rd_d;
            val_q <= val_d;
        end
    end

    assign q1_idx = bus.query_tag1 - 4'd1;
    assign q2_idx = bus.query_tag2 - 4'd1;

    always_comb begin
        bus.query_ready1 = 1'b0;
        bus.query_val1   = 32'd0;
        bus.query_ready2 = 1'b0;
        bus.query_val2   = 32'd0;
        if (tag_ok(bus.query_tag1) && busy_q[q1_idx] && done_q[q1_idx] && bcast_q[q1_idx]) begin
            bus.query_ready1 = 1'b1;
            bus.query_val1   = val_q[q1_idx];
        end
        if (tag_ok(bus.query_tag2) && busy_q[q2_idx] && done_q[q2_idx] && bcast_q[q2_idx]) begin
            bus.query_ready2 = 1'b1;
            bus.query_val2   = val_q[q2_idx];
        end
    end

    assign bus.rob_full     = full;
    assign bus.alloc_tag    = full ? 4'd0 : tail_q + 4'd1;
    assign bus.cdb_active   = cdb_active_q;
    assign bus.cdb_tag      = cdb_tag_q;
    assign bus.cdb_val      = cdb_val_q;
    assign bus.commit_valid = commit_valid_q;
    assign bus.commit_rd    = commit_rd_q;
    assign bus.commit_tag   = commit_tag_q;
    assign bus.commit_val   = commit_val_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed scenarios for the reorder buffer: allocation, broadcast, in-order retire, full/wrap,
// port collisions, flush, rdy_in hold and asynchronous reset.
module tb_reorder_buffer;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    reorder_buffer_if bus ();

    reorder_buffer #(.DEPTH(8)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rdy_in      = 1'b1;
        bus.flush       = 1'b0;
        bus.alloc_valid = 1'b0;
        bus.alloc_rd    = 5'd0;
        bus.alu_valid   = 1'b0;
        bus.alu_tag     = 4'd0;
        bus.alu_val     = 32'd0;
        bus.lsb_valid   = 1'b0;
        bus.lsb_tag     = 4'd0;
        bus.lsb_val     = 32'd0;
        bus.query_tag1  = 4'd0;
        bus.query_tag2  = 4'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        #12;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic alloc_n(input int n, input logic [4:0] rd0);
        bus.alloc_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.alloc_rd = rd0 + 5'(i);
            tick();
        end
        bus.alloc_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.query_tag1 = 4'd1;
        rst = 1'b1;
        #3;
        checks++; if (bus.cdb_active !== 1'b0) begin errors++; $display("FAIL reset_cdb_active got %0b exp 0", bus.cdb_active); end
        checks++; if (bus.cdb_tag !== 4'd0 || bus.cdb_val !== 32'd0) begin errors++; $display("FAIL reset_cdb_data got %0d/%0h exp 0/0", bus.cdb_tag, bus.cdb_val); end
        checks++; if (bus.commit_valid !== 1'b0 || bus.commit_rd !== 5'd0 || bus.commit_tag !== 4'd0 || bus.commit_val !== 32'd0) begin errors++; $display("FAIL reset_commit got v=%0b rd=%0d exp all 0", bus.commit_valid, bus.commit_rd); end
        checks++; if (bus.rob_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", bus.rob_full); end
        checks++; if (bus.alloc_tag !== 4'd1) begin errors++; $display("FAIL reset_alloc_tag got %0d exp 1", bus.alloc_tag); end
        checks++; if (bus.query_ready1 !== 1'b0) begin errors++; $display("FAIL reset_query got %0b exp 0", bus.query_ready1); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alloc_broadcast();
        do_reset();
        bus.alloc_valid = 1'b1;
        bus.alloc_rd = 5'd5; #1;
        checks++; if (bus.alloc_tag !== 4'd1) begin errors++; $display("FAIL alloc_tag_a got %0d exp 1", bus.alloc_tag); end
        tick();
        bus.alloc_rd = 5'd6; #1;
        checks++; if (bus.alloc_tag !== 4'd2) begin errors++; $display("FAIL alloc_tag_b got %0d exp 2", bus.alloc_tag); end
        tick();
        bus.alloc_rd = 5'd7; #1;
        checks++; if (bus.alloc_tag !== 4'd3) begin errors++; $display("FAIL alloc_tag_c got %0d exp 3", bus.alloc_tag); end
        tick();
        bus.alloc_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_tag = 4'd2; bus.alu_val = 32'h2A;
        tick();
        bus.alu_valid = 1'b0;
        checks++; if (bus.cdb_active !== 1'b0) begin errors++; $display("FAIL cdb_early got %0b exp 0", bus.cdb_active); end
        tick();
        checks++; if (bus.cdb_active !== 1'b1 || bus.cdb_tag !== 4'd2 || bus.cdb_val !== 32'h2A) begin errors++; $display("FAIL cdb_tag2 got a=%0b t=%0d v=%0h exp 1/2/2a", bus.cdb_active, bus.cdb_tag, bus.cdb_val); end
        checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL no_commit_head got %0b exp 0", bus.commit_valid); end
        tick();
        checks++; if (bus.cdb_active !== 1'b0 || bus.commit_valid !== 1'b0) begin errors++; $display("FAIL idle_after_bcast got a=%0b c=%0b exp 0/0", bus.cdb_active, bus.commit_valid); end
    endtask

    task automatic test_in_order_commit();
        bus.alu_valid = 1'b1; bus.alu_tag = 4'd1; bus.alu_val = 32'h11;
        tick();
        bus.alu_valid = 1'b0;
        tick();
        checks++; if (bus.cdb_active !== 1'b1 || bus.cdb_tag !== 4'd1 || bus.cdb_val !== 32'h11) begin errors++; $display("FAIL cdb_tag1 got a=%0b t=%0d v=%0h exp 1/1/11", bus.cdb_active, bus.cdb_tag, bus.cdb_val); end
        checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL commit_too_early got %0b exp 0", bus.commit_valid); end
        tick();
        checks++; if (bus.commit_valid !== 1'b1 || bus.commit_rd !== 5'd5 || bus.commit_tag !== 4'd1 || bus.commit_val !== 32'h11) begin errors++; $display("FAIL commit_1 got v=%0b rd=%0d t=%0d val=%0h exp 1/5/1/11", bus.commit_valid, bus.commit_rd, bus.commit_tag, bus.commit_val); end
        tick();
        checks++; if (bus.commit_valid !== 1'b1 || bus.commit_rd !== 5'd6 || bus.commit_tag !== 4'd2 || bus.commit_val !== 32'h2A) begin errors++; $display("FAIL commit_2 got v=%0b rd=%0d t=%0d val=%0h exp 1/6/2/2a", bus.commit_valid, bus.commit_rd, bus.commit_tag, bus.commit_val); end
        tick();
        checks++; if (bus.commit_valid !== 1'b0) begin errors++; $display("FAIL commit_stop got %0b exp 0", bus.commit_valid); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        bus.alloc_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.alloc_rd = 5'(10 + i); #1;
            checks++; if (bus.alloc_tag !== 4'(i + 1)) begin errors++; $display("FAIL fill_tag_%0d got %0d exp %0d", i, bus.alloc_tag, i + 1); end
            tick();
        end
        checks++; if (bus.rob_full !== 1'b1 || bus.alloc_tag !== 4'd0) begin errors++; $display("FAIL full_flag got f=%0b t=%0d exp 1/0", bus.rob_full, bus.alloc_tag); end
        bus.alu_valid = 1'b1; bus.alu_tag = 4'd1; bus.alu_val = 32'h55;
        tick();
        bus.alu_valid = 1'b0;
        tick();
        checks++; if (bus.cdb_active !== 1'b1 || bus.cdb_tag !== 4'd1) begin errors++; $display("FAIL full_bcast got a=%0b t=%0d exp 1/1", bus.cdb_active, bus.cdb_tag); end
        checks++; if (bus.rob_full !== 1'b1 || bus.alloc_tag !== 4'd0) begin errors++; $display("FAIL full_held got f=%0b t=%0d exp 1/0", bus.rob_full, bus.alloc_tag); end
        tick();
        checks++; if (bus.commit_valid !== 1'b1 || bus.commit_rd !== 5'd10 || bus.commit_val !== 32'h55) begin errors++; $display("FAIL full_commit got v=%0b rd=%0d val=%0h exp 1/10/55", bus.commit_valid, bus.commit_rd, bus.commit_val); end
        checks++; if (bus.rob_full !== 1'b0 || bus.alloc_tag !== 4'd1) begin errors++; $display("FAIL wrap_tag got f=%0b t=%0d exp 0/1", bus.rob_full, bus.alloc_tag); end
        tick();
        bus.alloc_valid = 1'b0;
        #1;
        checks++; if (bus.rob_full !== 1'b1 || bus.alloc_tag !== 4'd0) begin errors++; $display("FAIL refill got f=%0b t=%0d exp 1/0", bus.rob_full, bus.alloc_tag); end
    endtask

    task automatic test_dual_ports();
        do_reset();
        alloc_n(4, 5'd1);
        bus.alu_valid = 1'b1; bus.alu_tag = 4'd3; bus.alu_val = 32'h33;
        bus.lsb_valid = 1'b1; bus.lsb_tag = 4'd4; bus.lsb_val = 32'h44;
        tick();
        bus.alu_valid = 1'b0; bus.lsb_valid = 1'b0;
        tick();
        checks++; if (bus.cdb_active !== 1'b1 || bus.cdb_tag !== 4'd3 || bus.cdb_val !== 32'h33) begin errors++; $display("FAIL dual_first got a=%0b t=%0d v=%0h exp 1/3/33", bus.cdb_active, bus.cdb_tag, bus.cdb_val); end
        tick();
        checks++; if (bus.cdb_active !== 1'b1 || bus.cdb_tag !== 4'd4 || bus.cdb_val !== 32'h44) begin errors++; $display("FAIL dual_second got a=%0b t=%0d v=%0h exp 1/4/44", bus.cdb_active, bus.cdb_tag, bus.cdb_val); end
        tick();
        checks++; if (bus.cdb_active !== 1'b0) begin errors++; $display("FAIL dual_idle got %0b exp 0", bus.cdb_active); end
        bus.alu_valid = 1'b1; bus.alu_tag = 4'd1; bus.alu_val = 32'hAA;
        bus.lsb_valid = 1'b1; bus.lsb_tag = 4'd1; bus.lsb_val = 32'hBB;
        tick();
        bus.alu_valid = 1'b0; bus.lsb_valid = 1'b0;
        tick();
        checks++; if (bus.cdb_active !== 1'b1 || bus.cdb_tag !== 4'd1 || bus.cdb_val !== 32'hAA) begin errors++; $display("FAIL collide_cdb got a=%0b t=%0d v=%0h exp 1/1/aa", bus.cdb_active, bus.cdb_tag, bus.cdb_val); end
        tick();
        checks++; if (bus.commit_valid !== 1'b1 || bus.commit_tag !== 4'd1 || bus.commit_val !== 32'hAA) begin errors++; $display("FAIL collide_commit got v=%0b t=%0d val=%0h exp 1/1/aa", bus.commit_valid, bus.commit_tag, bus.commit_val); end
        bus.query_tag1 = 4'd3; bus.query_tag2 = 4'd4; #1;
        checks++; if (bus.query_ready1 !== 1'b1 || bus.query_val1 !== 32'h33) begin errors++; $display("FAIL query_t3 got r=%0b v=%0h exp 1/33", bus.query_ready1, bus.query_val1); end
        checks++; if (bus.query_ready2 !== 1'b1 || bus.query_val2 !== 32'h44) begin errors++; $display("FAIL query_t4 got r=%0b v=%0h exp 1/44", bus.query_ready2, bus.query_val2); end
        bus.alu_valid = 1'b1; bus.alu_tag = 4'd3; bus.alu_val = 32'hFF;
        tick();
        bus.alu_valid = 1'b0;
        bus.query_tag2 = 4'd2; #1;
        checks++; if (bus.query_val1 !== 32'h33) begin errors++; $display("FAIL done_ignored got %0h exp 33", bus.query_val1); end
        checks++; if (bus.query_ready2 !== 1'b0 || bus.query_val2 !== 32'd0) begin errors++; $display("FAIL query_notdone got r=%0b v=%0h exp 0/0", bus.query_ready2, bus.query_val2); end
        bus.query_tag1 = 4'd0; #1;
        checks++; if (bus.query_ready1 !== 1'b0) begin errors++; $display("FAIL query_tag0 got %0b exp 0", bus.query_ready1); end
    endtask

    task automatic test_flush();
        do_reset();
        alloc_n(5, 5'd3);
        bus.alu_valid = 1'b1; bus.alu_tag = 4'd2; bus.alu_val = 32'h22;
        tick();
        bus.alu_valid = 1'b0;
        bus.flush = 1'b1;
        bus.alloc_valid = 1'b1; bus.alloc_rd = 5'd9;
        tick();
        bus.flush = 1'b0;
        bus.alloc_valid = 1'b0;
        #1;
        checks++; if (bus.cdb_active !== 1'b0 || bus.commit_valid !== 1'b0) begin errors++; $display("FAIL flush_outputs got a=%0b c=%0b exp 0/0", bus.cdb_active, bus.commit_valid); end
        checks++; if (bus.rob_full !== 1'b0 || bus.alloc_tag !== 4'd1) begin errors++; $display("FAIL flush_ptrs got f=%0b t=%0d exp 0/1", bus.rob_full, bus.alloc_tag); end
        tick();
        checks++; if (bus.cdb_active !== 1'b0) begin errors++; $display("FAIL flush_lost_bcast got %0b exp 0", bus.cdb_active); end
    endtask

    task automatic test_rdy_hold();
        do_reset();
        alloc_n(1, 5'd9);
        bus.alu_valid = 1'b1; bus.alu_tag = 4'd1; bus.alu_val = 32'h77;
        tick();
        bus.alu_valid = 1'b0;
        bus.query_tag1 = 4'd1;
        bus.rdy_in = 1'b0;
        bus.alloc_valid = 1'b1; bus.alloc_rd = 5'd4;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.cdb_active !== 1'b0 || bus.commit_valid !== 1'b0 || bus.query_ready1 !== 1'b0 || bus.alloc_tag !== 4'd2) begin errors++; $display("FAIL hold_%0d got a=%0b c=%0b q=%0b t=%0d exp 0/0/0/2", i, bus.cdb_active, bus.commit_valid, bus.query_ready1, bus.alloc_tag); end
        end
        bus.alloc_valid = 1'b0;
        bus.rdy_in = 1'b1;
        tick();
        checks++; if (bus.cdb_active !== 1'b1 || bus.cdb_tag !== 4'd1 || bus.cdb_val !== 32'h77) begin errors++; $display("FAIL resume_cdb got a=%0b t=%0d v=%0h exp 1/1/77", bus.cdb_active, bus.cdb_tag, bus.cdb_val); end
        checks++; if (bus.query_ready1 !== 1'b1 || bus.query_val1 !== 32'h77) begin errors++; $display("FAIL resume_query got r=%0b v=%0h exp 1/77", bus.query_ready1, bus.query_val1); end
        tick();
        checks++; if (bus.commit_valid !== 1'b1 || bus.commit_rd !== 5'd9 || bus.commit_val !== 32'h77) begin errors++; $display("FAIL resume_commit got v=%0b rd=%0d val=%0h exp 1/9/77", bus.commit_valid, bus.commit_rd, bus.commit_val); end
    endtask

    task automatic test_async_reset();
        do_reset();
        alloc_n(2, 5'd1);
        bus.lsb_valid = 1'b1; bus.lsb_tag = 4'd2; bus.lsb_val = 32'h99;
        tick();
        bus.lsb_valid = 1'b0;
        tick();
        checks++; if (bus.cdb_active !== 1'b1 || bus.cdb_tag !== 4'd2) begin errors++; $display("FAIL pre_rst_cdb got a=%0b t=%0d exp 1/2", bus.cdb_active, bus.cdb_tag); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.cdb_active !== 1'b0 || bus.cdb_tag !== 4'd0 || bus.alloc_tag !== 4'd1) begin errors++; $display("FAIL async_rst got a=%0b t=%0d at=%0d exp 0/0/1", bus.cdb_active, bus.cdb_tag, bus.alloc_tag); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_alloc_broadcast();
        test_in_order_commit();
        test_full_wrap();
        test_dual_ports();
        test_flush();
        test_rdy_hold();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
